// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - register indices (Address_i[3:2]) inside the 16-byte window
//   - STATUS register bit positions
//   - transmit FSM state encoding
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_TX_ACTIVE = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push, wdata    enqueue wdata; ignored when full
//   pop            dequeue head; ignored when empty
//   rdata          current head entry (combinational)
//   full, empty    occupancy flags
//   count          number of valid entries, 0..DEPTH
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   Write_Data_i    bus write data
//   Address_i       bus byte address (16-byte window at BASE_ADDR)
//   Mem_Write_i     write strobe, sampled at rising clk
//   Mem_Read_i      read enable, combinational read path
//   Read_Data_o     read data, 0 unless selected and reading
//   tx_o            registered serial output, idle high
//   busy_o          frame in flight or FIFO non-empty
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for one bit period
// S_DATA  | eight data bits, LSB first, one bit period each
// S_STOP  | stop bit (high); chains straight into the next frame
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h1001_0000,
  parameter int          FIFO_DEPTH       = 4,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Write_Data_i,
  input  logic [31:0] Address_i,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  output logic [31:0] Read_Data_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [1:0]    reg_idx;
  logic          wr_en;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          overflow_q;
  logic [15:0]   baud_div_q;
  logic          tx_active;
  logic [31:0]   status_word;

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;

  logic          unused_bits;
  assign unused_bits = ^{Address_i[1:0], Write_Data_i[31:16]};

  assign sel       = (Address_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx   = Address_i[3:2];
  assign wr_en     = sel && Mem_Write_i;
  assign fifo_push = wr_en && (reg_idx == REG_TXDATA);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (Write_Data_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register file. A push into a full FIFO is dropped inside the FIFO
  // (full is the pre-edge value, so a same-cycle pop does not rescue it).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      baud_div_q <= DEFAULT_BAUD_DIV;
    end else begin
      if (wr_en && (reg_idx == REG_STATUS) && Write_Data_i[ST_OVERFLOW])
        overflow_q <= 1'b0;
      else if (fifo_push && fifo_full)
        overflow_q <= 1'b1;
      if (wr_en && (reg_idx == REG_BAUD_DIV))
        baud_div_q <= Write_Data_i[15:0];
    end
  end

  assign tx_active = (state_q != S_IDLE);
  assign busy_o    = tx_active | ~fifo_empty;
  assign tx_o      = tx_q;

  always_comb begin
    status_word                             = '0;
    status_word[ST_FULL]                    = fifo_full;
    status_word[ST_EMPTY]                   = fifo_empty;
    status_word[ST_TX_ACTIVE]               = tx_active;
    status_word[ST_OVERFLOW]                = overflow_q;
    status_word[ST_COUNT_LSB +: CW]         = fifo_count;
  end

  always_comb begin
    Read_Data_o = '0;
    if (sel && Mem_Read_i) begin
      case (reg_idx)
        REG_STATUS:   Read_Data_o = status_word;
        REG_BAUD_DIV: Read_Data_o = {16'h0000, baud_div_q};
        default:      Read_Data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
    end
  end

  // tx_d is the line level for the bit that begins at the next edge, so
  // the registered output changes exactly on bit boundaries.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = fifo_rdata;
          baud_cnt_d = baud_div_q;
          state_d    = S_START;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (baud_cnt_q == '0) begin
          baud_cnt_d = baud_div_q;
          bit_idx_d  = 3'd0;
          state_d    = S_DATA;
          tx_d       = shreg_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_cnt_q == '0) begin
          baud_cnt_d = baud_div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[bit_idx_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shreg_d    = fifo_rdata;
            baud_cnt_d = baud_div_q;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule
